// File: rtl/kid_vertical_ctrl_pkg.sv
// Shared types and motion constants for the Kid's vertical controller.
// All constants are unsigned magnitudes and are negated where an upward speed is needed.
package kid_pkg;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } kid_vstate_t;

    localparam logic [9:0] INIT_Y    = 10'd416;
    localparam logic [9:0] GRAVITY   = 10'd1;
    localparam logic [9:0] JUMP_V    = 10'd8;
    localparam logic [9:0] DJUMP_V   = 10'd6;
    localparam logic [9:0] MAX_FALL  = 10'd8;
    localparam logic [9:0] RELEASE_V = 10'd2;
    localparam logic [1:0] MAX_JUMPS = 2'd2;

    // Widen a 10-bit two's-complement velocity so signed compares cannot overflow.
    function automatic logic signed [10:0] sext11(input logic [9:0] v);
        return $signed({v[9], v});
    endfunction

endpackage

// File: rtl/kid_vertical_ctrl_key_edge.sv
// Rise/fall pulse generator for a level input that is already synchronous to clk.
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic prev_q;
    logic prev_d;

    // Next value of the delayed copy of the level.
    always_comb begin
        prev_d = level;
    end

    // Delayed copy of the level; cleared so a key held across reset reads as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/kid_vertical_ctrl.sv
// Frame-rate vertical motion controller: gravity, double jump and release-to-cut jump height.
// Velocity goes out to the wall-set, whose collision answers are committed on the next frame tick.
module kid_vertical_ctrl
    import kid_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       jump_key,
    input  logic       hit_y,
    input  logic       hit_top,
    input  logic [9:0] Kid_position_Y_hit,
    input  logic [9:0] Kid_position_Y_top,
    input  logic       Ground,
    output logic [9:0] Kid_position_Y,
    output logic [9:0] Kid_move_Y,
    output logic       on_ground,
    output logic [1:0] jumps_used
);

    kid_vstate_t state_q, state_d, state_a;
    logic [9:0]  y_q, y_d, y_a, y_snap_s;
    logic [9:0]  vel_q, vel_d, vel_a, vel_b, neg_vel_s;
    logic [1:0]  jumps_q, jumps_d, jumps_a;
    logic        press_pend_q, press_pend_d;
    logic        rel_pend_q, rel_pend_d;
    logic        key_rise_s, key_fall_s;
    logic        press_now_s, rel_now_s, jump_ok_s, rel_cap_s;
    logic signed [10:0] vel_inc_s, rel_lim_s;

    key_edge u_key_edge (
        .clk   (Clk),
        .rst   (Reset),
        .level (jump_key),
        .rise  (key_rise_s),
        .fall  (key_fall_s)
    );

    // Frame update: collisions, free motion with clamps, then jump and release adjustments.
    always_comb begin
        y_a         = y_q;
        vel_a       = vel_q;
        state_a     = state_q;
        jumps_a     = jumps_q;
        press_now_s = press_pend_q | key_rise_s;
        rel_now_s   = rel_pend_q | key_fall_s;
        neg_vel_s   = 10'd0 - vel_q;
        vel_inc_s   = sext11(vel_q) + $signed({1'b0, GRAVITY});
        rel_lim_s   = 11'sd0 - $signed({1'b0, RELEASE_V});
        y_snap_s    = hit_y ? Kid_position_Y_hit : (hit_top ? Kid_position_Y_top : y_q);

        if (hit_y) begin
            y_a     = Kid_position_Y_hit;
            vel_a   = 10'd0;
            jumps_a = 2'd0;
            state_a = GROUNDED;
        end else if (hit_top) begin
            y_a     = Kid_position_Y_top;
            vel_a   = 10'd0;
            state_a = FALLING;
        end else if ((state_q == GROUNDED) && Ground) begin
            y_a     = y_q;
            vel_a   = vel_q;
        end else if (vel_q[9] && (y_q < neg_vel_s)) begin
            // Moving up past the screen top: pin at row 0 instead of wrapping.
            y_a     = 10'd0;
            vel_a   = 10'd0;
            state_a = FALLING;
        end else begin
            y_a = y_q + vel_q;
            if (vel_inc_s > $signed({1'b0, MAX_FALL})) begin
                vel_a = MAX_FALL;
            end else begin
                vel_a = vel_inc_s[9:0];
            end
            if (state_q == GROUNDED) begin
                state_a = FALLING;
                jumps_a = 2'd1;
            end else if ((state_q == RISING) && !vel_inc_s[10]) begin
                state_a = FALLING;
            end else begin
                state_a = state_q;
            end
        end

        jump_ok_s = press_now_s && (jumps_a < MAX_JUMPS);
        vel_b     = jump_ok_s ? ((jumps_a == 2'd0) ? (10'd0 - JUMP_V) : (10'd0 - DJUMP_V)) : vel_a;
        rel_cap_s = rel_now_s && (sext11(vel_b) < rel_lim_s);

        if (frame_tick) begin
            y_d          = jump_ok_s ? y_snap_s : y_a;
            vel_d        = rel_cap_s ? (10'd0 - RELEASE_V) : vel_b;
            jumps_d      = jump_ok_s ? (jumps_a + 2'd1) : jumps_a;
            state_d      = jump_ok_s ? RISING : state_a;
            press_pend_d = 1'b0;
            rel_pend_d   = 1'b0;
        end else begin
            y_d          = y_q;
            vel_d        = vel_q;
            jumps_d      = jumps_q;
            state_d      = state_q;
            press_pend_d = press_now_s;
            rel_pend_d   = rel_now_s;
        end
    end

    // State, datapath and pending-key registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= GROUNDED;
            y_q          <= INIT_Y;
            vel_q        <= 10'd0;
            jumps_q      <= 2'd0;
            press_pend_q <= 1'b0;
            rel_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            vel_q        <= vel_d;
            jumps_q      <= jumps_d;
            press_pend_q <= press_pend_d;
            rel_pend_q   <= rel_pend_d;
        end
    end

    assign Kid_position_Y = y_q;
    assign Kid_move_Y     = vel_q;
    assign on_ground      = (state_q == GROUNDED);
    assign jumps_used     = jumps_q;

endmodule

// File: tb/tb_kid_vertical_ctrl.sv
// Directed and randomized check of kid_vertical_ctrl against an integer motion model.
module tb_kid_vertical_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       jump_key = 1'b0;
    logic       hit_y = 1'b0;
    logic       hit_top = 1'b0;
    logic [9:0] Kid_position_Y_hit = 10'd0;
    logic [9:0] Kid_position_Y_top = 10'd0;
    logic       Ground = 1'b1;
    logic [9:0] Kid_position_Y;
    logic [9:0] Kid_move_Y;
    logic       on_ground;
    logic [1:0] jumps_used;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: position, signed velocity, jump count, standing flag, pending key events.
    int m_y, m_v, m_j;
    bit m_ground, m_press, m_rel;

    kid_vertical_ctrl dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .frame_tick         (frame_tick),
        .jump_key           (jump_key),
        .hit_y              (hit_y),
        .hit_top            (hit_top),
        .Kid_position_Y_hit (Kid_position_Y_hit),
        .Kid_position_Y_top (Kid_position_Y_top),
        .Ground             (Ground),
        .Kid_position_Y     (Kid_position_Y),
        .Kid_move_Y         (Kid_move_Y),
        .on_ground          (on_ground),
        .jumps_used         (jumps_used)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_y = 416; m_v = 0; m_j = 0; m_ground = 1'b1; m_press = 1'b0; m_rel = 1'b0;
    endtask

    task automatic model_step();
        int  y_old;
        bit  p, rl;
        p = m_press; rl = m_rel; m_press = 1'b0; m_rel = 1'b0;
        y_old = m_y;
        if (hit_y) begin
            m_y = int'(Kid_position_Y_hit); m_v = 0; m_j = 0; m_ground = 1'b1;
        end else if (hit_top) begin
            m_y = int'(Kid_position_Y_top); m_v = 0; m_ground = 1'b0;
        end else if (m_ground && Ground) begin
            m_y = m_y;
        end else if (m_v < 0 && m_y < -m_v) begin
            m_y = 0; m_v = 0; m_ground = 1'b0;
        end else begin
            m_y = (m_y + m_v) & 1023;
            m_v = (m_v + 1 > 8) ? 8 : m_v + 1;
            if (m_ground) begin
                m_ground = 1'b0;
                m_j = 1;
            end
        end
        if (p && m_j < 2) begin
            m_v = (m_j == 0) ? -8 : -6;
            if (!hit_y && !hit_top) m_y = y_old;
            m_j++;
            m_ground = 1'b0;
        end
        if (rl && m_v < -2) m_v = -2;
    endtask

    task automatic check_model();
        chk("pos_y", Kid_position_Y, 10'(m_y));
        chk("move_y", Kid_move_Y, 10'(m_v));
        chk("on_ground", 10'(on_ground), 10'(m_ground));
        chk("jumps_used", 10'(jumps_used), 10'(m_j));
    endtask

    task automatic check_const(input logic [9:0] y, input logic [9:0] v,
                               input logic g, input logic [1:0] j);
        chk("k_pos_y", Kid_position_Y, y);
        chk("k_move_y", Kid_move_Y, v);
        chk("k_on_ground", 10'(on_ground), 10'(g));
        chk("k_jumps", 10'(jumps_used), 10'(j));
    endtask

    task automatic set_key(input logic v);
        @(negedge Clk);
        if (v && !jump_key) m_press = 1'b1;
        if (!v && jump_key) m_rel = 1'b1;
        jump_key = v;
    endtask

    task automatic tick_hit(input logic hy, input logic [9:0] yh, input logic ht, input logic [9:0] yt);
        @(negedge Clk);
        hit_y = hy; Kid_position_Y_hit = yh;
        hit_top = ht; Kid_position_Y_top = yt;
        frame_tick = 1'b1;
        @(posedge Clk);
        model_step();
        #1;
        frame_tick = 1'b0; hit_y = 1'b0; hit_top = 1'b0;
        check_model();
    endtask

    task automatic tick();
        tick_hit(1'b0, 10'd0, 1'b0, 10'd0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        check_const(10'd416, 10'd0, 1'b1, 2'd0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Idle standing on the floor.
        repeat (3) tick();
        check_const(10'd416, 10'd0, 1'b1, 2'd0);

        // First jump and free rise.
        set_key(1'b1);
        tick();
        check_const(10'd416, 10'h3F8, 1'b0, 2'd1);
        tick();
        check_const(10'd408, 10'h3F9, 1'b0, 2'd1);
        tick();
        check_const(10'd401, 10'h3FA, 1'b0, 2'd1);
        repeat (3) tick();
        check_const(10'd386, 10'h3FD, 1'b0, 2'd1);

        // Release at -3 is above the cap; second jump; third press ignored but release caps.
        set_key(1'b0);
        tick();
        check_const(10'd383, 10'h3FE, 1'b0, 2'd1);
        set_key(1'b1);
        tick();
        check_const(10'd383, 10'h3FA, 1'b0, 2'd2);
        set_key(1'b0);
        set_key(1'b1);
        tick();
        check_const(10'd377, 10'h3FE, 1'b0, 2'd2);

        // Landing snap.
        tick_hit(1'b1, 10'd350, 1'b0, 10'd0);
        check_const(10'd350, 10'd0, 1'b1, 2'd0);

        // Release shortly after launch cuts the rise.
        set_key(1'b0);
        tick();
        set_key(1'b1);
        tick();
        check_const(10'd350, 10'h3F8, 1'b0, 2'd1);
        tick();
        check_const(10'd342, 10'h3F9, 1'b0, 2'd1);
        set_key(1'b0);
        tick();
        check_const(10'd335, 10'h3FE, 1'b0, 2'd1);

        // Head hit.
        set_key(1'b1);
        tick();
        check_const(10'd335, 10'h3FA, 1'b0, 2'd2);
        tick_hit(1'b0, 10'd0, 1'b1, 10'd160);
        check_const(10'd160, 10'd0, 1'b0, 2'd2);

        // Screen-top clamp.
        set_key(1'b0);
        tick_hit(1'b1, 10'd5, 1'b0, 10'd0);
        set_key(1'b1);
        tick();
        check_const(10'd5, 10'h3F8, 1'b0, 2'd1);
        tick();
        check_const(10'd0, 10'd0, 1'b0, 2'd1);

        // Ledge walk-off then air jump, then reset mid-rise.
        set_key(1'b0);
        tick_hit(1'b1, 10'd200, 1'b0, 10'd0);
        Ground = 1'b0;
        tick();
        check_const(10'd200, 10'd1, 1'b0, 2'd1);
        set_key(1'b1);
        tick();
        check_const(10'd200, 10'h3FA, 1'b0, 2'd2);
        tick();
        check_const(10'd194, 10'h3FB, 1'b0, 2'd2);
        set_key(1'b0);
        Ground = 1'b1;
        do_reset();
        tick();
        check_const(10'd416, 10'd0, 1'b1, 2'd0);

        // Outputs hold between ticks.
        repeat (3) @(negedge Clk);
        check_model();

        // Randomized play against the model.
        for (int i = 0; i < 400; i++) begin
            int nk;
            nk = $urandom_range(0, 2);
            for (int k = 0; k < nk; k++) set_key(1'($urandom_range(0, 1)));
            Ground = ($urandom_range(0, 3) != 0);
            tick_hit(($urandom_range(0, 7) == 0), 10'($urandom_range(0, 1023)),
                     ($urandom_range(0, 9) == 0), 10'($urandom_range(0, 1023)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
